// File: rtl/regfile_writeback_if.sv
// Bundle of write-back traffic: ALU results, load issue, memory responses and
// the register-file write port with its scoreboard outputs.
interface regfile_writeback_if #(
    parameter int LQ_DEPTH = 4
);
    localparam int LQW = $clog2(LQ_DEPTH) + 1;

    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [31:0]     alu_data;
    logic            ld_issue_valid;
    logic            ld_issue_ready;
    logic [4:0]      ld_issue_rd;
    logic [2:0]      ld_issue_funct3;
    logic [1:0]      ld_issue_addr_lo;
    logic            mem_rvalid;
    logic [31:0]     mem_rdata;
    logic            we3;
    logic [4:0]      a3;
    logic [31:0]     wd3;
    logic [31:0]     busy;
    logic [LQW-1:0]  lq_count;
    logic            err_sticky;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
        output mem_rvalid, mem_rdata,
        input  alu_ready, ld_issue_ready,
        input  we3, a3, wd3, busy, lq_count, err_sticky
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue_valid, ld_issue_rd, ld_issue_funct3, ld_issue_addr_lo,
        input  mem_rvalid, mem_rdata,
        output alu_ready, ld_issue_ready,
        output we3, a3, wd3, busy, lq_count, err_sticky
    );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: ALU results and in-order load responses share
// one registered write port; a busy scoreboard tracks registers with pending loads.
module regfile_writeback #(
    parameter int LQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    regfile_writeback_if.slave   bus
);
    localparam int LQW = $clog2(LQ_DEPTH) + 1;
    localparam int PW  = $clog2(LQ_DEPTH);

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } lq_entry_t;

    lq_entry_t       lq_q [LQ_DEPTH];
    lq_entry_t       lq_d [LQ_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [LQW-1:0]  lq_count_q, lq_count_d;
    logic [31:0]     busy_q, busy_d;
    logic            err_q, err_d;
    logic            we3_q, we3_d;
    logic [4:0]      a3_q, a3_d;
    logic [31:0]     wd3_q, wd3_d;

    logic            alu_fire;
    logic            issue_fire;
    logic            retire;
    lq_entry_t       head_entry;

    function automatic logic [31:0] extract_load(input logic [2:0]  funct3,
                                                 input logic [1:0]  addr_lo,
                                                 input logic [31:0] word);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] byte_ext;
        logic signed [31:0] half_ext;
        byte_s   = word[{addr_lo, 3'b000} +: 8];
        half_s   = word[{addr_lo[1], 4'b0000} +: 16];
        byte_ext = byte_s;
        half_ext = half_s;
        case (funct3)
            3'b000:  return $unsigned(byte_ext);
            3'b100:  return {24'd0, byte_s};
            3'b001:  return $unsigned(half_ext);
            3'b101:  return {16'd0, half_s};
            default: return word;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic [2:0] funct3);
        return funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Memory responses cannot be back-pressured, so they always win the write port.
    assign bus.alu_ready      = resetn && !bus.mem_rvalid;
    assign bus.ld_issue_ready = resetn && (lq_count_q < LQW'(LQ_DEPTH)) &&
                                (bus.ld_issue_rd == 5'd0 || !busy_q[bus.ld_issue_rd]);

    assign alu_fire   = bus.alu_valid && bus.alu_ready;
    assign issue_fire = bus.ld_issue_valid && bus.ld_issue_ready;
    assign retire     = bus.mem_rvalid && (lq_count_q != '0);
    assign head_entry = lq_q[head_q];

    always_comb begin
        lq_d       = lq_q;
        head_d     = head_q;
        tail_d     = tail_q;
        lq_count_d = lq_count_q + LQW'(issue_fire) - LQW'(retire);
        busy_d     = busy_q;
        err_d      = err_q;
        we3_d      = 1'b0;
        a3_d       = a3_q;
        wd3_d      = wd3_q;

        if (bus.mem_rvalid) begin
            if (retire) begin
                head_d = head_q + PW'(1);
                a3_d   = head_entry.rd;
                wd3_d  = extract_load(head_entry.funct3, head_entry.addr_lo, bus.mem_rdata);
                we3_d  = (head_entry.rd != 5'd0);
                busy_d[head_entry.rd] = 1'b0;
                if (!funct3_legal(head_entry.funct3)) err_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (alu_fire) begin
            a3_d  = bus.alu_rd;
            wd3_d = bus.alu_data;
            we3_d = (bus.alu_rd != 5'd0);
            if (bus.alu_rd != 5'd0 && busy_q[bus.alu_rd]) err_d = 1'b1;
        end

        if (issue_fire) begin
            lq_d[tail_q] = '{rd: bus.ld_issue_rd, funct3: bus.ld_issue_funct3,
                             addr_lo: bus.ld_issue_addr_lo};
            tail_d = tail_q + PW'(1);
            busy_d[bus.ld_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            lq_count_q <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            lq_count_q <= lq_count_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            we3_q      <= we3_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
        end
        lq_q <= lq_d;
    end

    assign bus.we3        = we3_q;
    assign bus.a3         = a3_q;
    assign bus.wd3        = wd3_q;
    assign bus.busy       = busy_q;
    assign bus.lq_count   = lq_count_q;
    assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: a queue-based reference model is compared
// every cycle, with literal expectations for the hand-computed scenarios.
module tb_regfile_writeback;
    localparam int LQ_DEPTH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    regfile_writeback_if #(.LQ_DEPTH(LQ_DEPTH)) bus ();
    regfile_writeback #(.LQ_DEPTH(LQ_DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] lo;
    } ld_t;

    ld_t         mq[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd3 = '0;
    logic        m_err = 1'b0;
    bit          m_known = 1'b0;
    bit          started = 1'b0;

    function automatic bit m_busy(input logic [4:0] r);
        foreach (mq[i]) if (r != 0 && mq[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        foreach (mq[i]) if (mq[i].rd != 0) v = v | (32'd1 << mq[i].rd);
        return v;
    endfunction

    function automatic logic [31:0] m_load(input ld_t e, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * e.lo)) & 32'hFF;
        h = (w >> (16 * (e.lo / 2))) & 32'hFFFF;
        case (e.f3)
            3'd0:    return b[7]  ? (b | 32'hFFFFFF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic m_write(input logic [4:0] rd, input logic [31:0] d);
        if (rd == 0) begin
            m_known = 1'b0;
        end else begin
            m_we = 1'b1; m_a3 = rd; m_wd3 = d; m_known = 1'b1;
        end
    endtask

    always @(posedge clk) begin : model
        bit  ldr;
        ld_t e;
        if (!resetn) begin
            mq.delete();
            m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_err = 1'b0;
            m_known = 1'b1; started = 1'b1;
        end else begin
            ldr  = (mq.size() < LQ_DEPTH) && !m_busy(bus.ld_issue_rd);
            m_we = 1'b0;
            if (bus.mem_rvalid) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    m_write(e.rd, m_load(e, bus.mem_rdata));
                    if (!(e.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) m_err = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end else if (bus.alu_valid) begin
                if (bus.alu_rd != 0 && m_busy(bus.alu_rd)) m_err = 1'b1;
                m_write(bus.alu_rd, bus.alu_data);
            end
            if (bus.ld_issue_valid && ldr)
                mq.push_back('{rd: bus.ld_issue_rd, f3: bus.ld_issue_funct3, lo: bus.ld_issue_addr_lo});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("we3", 32'(bus.we3), 32'(m_we));
            if (m_known) begin
                chk("a3", 32'(bus.a3), 32'(m_a3));
                chk("wd3", bus.wd3, m_wd3);
            end
            chk("busy", bus.busy, m_busy_vec());
            chk("lq_count", 32'(bus.lq_count), mq.size());
            chk("err_sticky", 32'(bus.err_sticky), 32'(m_err));
            chk("alu_ready", 32'(bus.alu_ready), 32'(resetn && !bus.mem_rvalid));
            chk("ld_issue_ready", 32'(bus.ld_issue_ready),
                32'(resetn && (mq.size() < LQ_DEPTH) && !m_busy(bus.ld_issue_rd)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_issue_valid = 1'b0; bus.ld_issue_rd = '0;
        bus.ld_issue_funct3 = '0; bus.ld_issue_addr_lo = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = rd;
        bus.ld_issue_funct3 = f3; bus.ld_issue_addr_lo = lo;
        cyc();
        bus.ld_issue_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = d;
        cyc();
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        idle();
        resetn = 1'b0;
        cyc(); cyc();
        chk("rst_we3", 32'(bus.we3), 0);
        chk("rst_a3", 32'(bus.a3), 0);
        chk("rst_wd3", bus.wd3, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_lq_count", 32'(bus.lq_count), 0);
        chk("rst_err", 32'(bus.err_sticky), 0);
        resetn = 1'b1;

        // ALU write, one-cycle pulse
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        #1 chk("alu_ready_lit", 32'(bus.alu_ready), 1);
        cyc();
        bus.alu_valid = 1'b0;
        chk("alu_we3", 32'(bus.we3), 1);
        chk("alu_a3", 32'(bus.a3), 5);
        chk("alu_wd3", bus.wd3, 32'hDEADBEEF);
        cyc();
        chk("alu_we3_drop", 32'(bus.we3), 0);

        // Extraction variants
        issue(5'd7, 3'd0, 2'd3);
        chk("lb_busy7", 32'(bus.busy[7]), 1);
        cyc();
        chk("lb_busy7_hold", 32'(bus.busy[7]), 1);
        respond(32'h80FFFF00);
        chk("lb_wd3", bus.wd3, 32'hFFFFFF80);
        chk("lb_busy_clr", bus.busy, 0);
        issue(5'd7, 3'd4, 2'd3); respond(32'h80FFFF00);
        chk("lbu_wd3", bus.wd3, 32'h00000080);
        issue(5'd7, 3'd1, 2'd2); respond(32'h80FFFF00);
        chk("lh_wd3", bus.wd3, 32'hFFFF80FF);
        issue(5'd7, 3'd5, 2'd3); respond(32'h80FFFF00);
        chk("lhu_wd3", bus.wd3, 32'h000080FF);
        issue(5'd7, 3'd2, 2'd1); respond(32'h12345678);
        chk("lw_wd3", bus.wd3, 32'h12345678);
        issue(5'd6, 3'd0, 2'd1); respond(32'h00007F00);
        chk("lb_pos_wd3", bus.wd3, 32'h0000007F);
        chk("lb_pos_a3", 32'(bus.a3), 6);

        // Fill the queue, then issue+retire on a full queue
        for (int i = 1; i <= 4; i++) issue(5'(i), 3'd2, 2'd0);
        chk("full_count", 32'(bus.lq_count), 4);
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd5; bus.ld_issue_funct3 = 3'd2;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h101;
        #1 chk("full_issue_ready", 32'(bus.ld_issue_ready), 0);
        cyc();
        bus.ld_issue_valid = 1'b0;
        chk("drain1_a3", 32'(bus.a3), 1);
        chk("drain1_count", 32'(bus.lq_count), 3);
        for (int i = 2; i <= 4; i++) begin
            bus.mem_rdata = 32'h100 + 32'(i);
            cyc();
            chk("drain_a3", 32'(bus.a3), 32'(i));
            chk("drain_wd3", bus.wd3, 32'h100 + 32'(i));
        end
        bus.mem_rvalid = 1'b0;
        chk("drain_busy", bus.busy, 0);
        chk("drain_count", 32'(bus.lq_count), 0);

        // ALU collides with a memory response
        issue(5'd10, 3'd2, 2'd0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'h1111;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE;
        #1 chk("coll_alu_ready", 32'(bus.alu_ready), 0);
        cyc();
        bus.mem_rvalid = 1'b0;
        chk("coll_ld_a3", 32'(bus.a3), 10);
        chk("coll_ld_wd3", bus.wd3, 32'hCAFE);
        cyc();
        bus.alu_valid = 1'b0;
        chk("coll_alu_a3", 32'(bus.a3), 11);
        chk("coll_alu_wd3", bus.wd3, 32'h1111);
        chk("coll_err", 32'(bus.err_sticky), 0);

        // Write-after-write on pending load
        issue(5'd9, 3'd2, 2'd0);
        bus.ld_issue_valid = 1'b1; bus.ld_issue_rd = 5'd9;
        #1 chk("waw_ready", 32'(bus.ld_issue_ready), 0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
        cyc();
        bus.alu_valid = 1'b0;
        chk("waw_err", 32'(bus.err_sticky), 1);
        chk("waw_alu_wd3", bus.wd3, 32'h99);
        chk("waw_count", 32'(bus.lq_count), 1);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h900;
        #1 chk("waw_retire_ready", 32'(bus.ld_issue_ready), 0);
        cyc();
        bus.mem_rvalid = 1'b0;
        chk("waw_ret_wd3", bus.wd3, 32'h900);
        chk("waw_ret_count", 32'(bus.lq_count), 0);
        #1 chk("waw_ready_after", 32'(bus.ld_issue_ready), 1);
        cyc();
        bus.ld_issue_valid = 1'b0;
        chk("waw_reissue_count", 32'(bus.lq_count), 1);
        respond(32'h901);

        // x0 handling and empty-queue response
        do_reset();
        issue(5'd0, 3'd2, 2'd0);
        chk("x0_count", 32'(bus.lq_count), 1);
        chk("x0_busy", bus.busy, 0);
        respond(32'h55);
        chk("x0_ld_we3", 32'(bus.we3), 0);
        chk("x0_pop", 32'(bus.lq_count), 0);
        chk("x0_err", 32'(bus.err_sticky), 0);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h77;
        cyc();
        bus.alu_valid = 1'b0;
        chk("x0_alu_we3", 32'(bus.we3), 0);
        respond(32'h66);
        chk("empty_err", 32'(bus.err_sticky), 1);
        chk("empty_we3", 32'(bus.we3), 0);

        // Illegal funct3
        do_reset();
        issue(5'd12, 3'd3, 2'd0); respond(32'hABCD);
        chk("bad_we3", 32'(bus.we3), 1);
        chk("bad_a3", 32'(bus.a3), 12);
        chk("bad_wd3", bus.wd3, 32'hABCD);
        chk("bad_err", 32'(bus.err_sticky), 1);

        // Reset with loads outstanding, then a stray response
        do_reset();
        issue(5'd13, 3'd0, 2'd0);
        issue(5'd14, 3'd0, 2'd0);
        chk("mid_count", 32'(bus.lq_count), 2);
        do_reset();
        chk("mid_rst_count", 32'(bus.lq_count), 0);
        chk("mid_rst_busy", bus.busy, 0);
        respond(32'h1);
        chk("stray_err", 32'(bus.err_sticky), 1);
        chk("stray_we3", 32'(bus.we3), 0);

        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Drives the register file's single write port (we3/a3/wd3) from two sources: single-cycle ALU results and multi-cycle load responses. Holds an in-order queue of outstanding loads and performs byte/halfword extraction with sign or zero extension. Keeps a per-register busy scoreboard that decode uses to stall on pending load destinations. Sits between the execute/memory stages and the register file.

Parameters:
LQ_DEPTH, 4, load-queue entries; must be a power of 2 and at least 2
LQW, $clog2(LQ_DEPTH)+1, width of lq_count (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous, active-low reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
ld_issue_valid  in  1  load issued to memory this cycle
ld_issue_ready  out  1  load issue accepted
ld_issue_rd  in  5  load destination
ld_issue_funct3  in  3  load type (RV32I funct3)
ld_issue_addr_lo  in  2  address bits [1:0]
mem_rvalid  in  1  memory read data valid (one beat per issued load, in order)
mem_rdata  in  32  memory read word
we3  out  1  regfile write enable
a3  out  5  regfile write address
wd3  out  32  regfile write data
busy  out  32  bit i set while a load to register xi is queued
lq_count  out  LQW  queued loads
err_sticky  out  1  protocol-violation flag, cleared only by reset

Behaviour:
- Reset (resetn=0 at a rising edge): we3=0, a3=0, wd3=0, busy=0, lq_count=0, err_sticky=0. Queue pointers are zeroed. Pending loads are dropped.
- Write port is registered. A source accepted at edge N gives we3=1 with the matching a3/wd3 for exactly one cycle after edge N. With no source accepted, we3=0 and a3/wd3 hold their previous values.
- Arbitration: mem_rvalid has priority. alu_ready = resetn && !mem_rvalid. This is combinational and documented as such. ALU handshake fires when alu_valid && alu_ready.
- Load response retire: when mem_rvalid=1 and the queue is non-empty, pop the head entry {rd, funct3, addr_lo} and produce the data as follows:
  - 000 LB: byte mem_rdata[8*addr_lo+:8], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword mem_rdata[16*addr_lo[1]+:16], sign-extended; addr_lo[0] is ignored.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: mem_rdata unchanged.
  - Any other funct3: wd3=mem_rdata and err_sticky set.
- Response with empty queue: ignored (no write) and err_sticky set.
- x0: any write with rd=0 gives we3=0 for that cycle. A load to x0 is still queued and popped, and its busy bit is never set. busy[0] is always 0.
- Load issue: ld_issue_ready = resetn && (lq_count < LQ_DEPTH) && (ld_issue_rd==0 || !busy[ld_issue_rd]). This blocks a write-after-write on a pending load. Readiness uses the current-cycle count and busy, so a retire in the same cycle does not free space or clear busy for that cycle's issue. On a handshake, push the entry and set busy[rd] (rd≠0) at the edge.
- Scoreboard: busy[rd] clears at the edge where its load retires. Issue-block guarantees at most one queued entry per nonzero rd. Simultaneous issue and retire in one cycle: both occur and lq_count is unchanged.
- An accepted ALU write with alu_rd≠0 and busy[alu_rd]=1 is still performed, and err_sticky is set. Decode is required to stall on busy.
- Queue is a circular buffer. Pointers wrap modulo LQ_DEPTH, and lq_count ranges 0..LQ_DEPTH.
- Stray mem_rvalid after a mid-operation reset: treated as empty-queue response (err_sticky set). The memory subsystem is reset on the same resetn.

Test Plan:
- Reset then alu_valid, rd=5, data=0xDEADBEEF → alu_ready=1; next cycle we3=1, a3=5, wd3=0xDEADBEEF; following cycle we3=0.
- Issue LB rd=7 addr_lo=3, then mem_rdata=0x80FF_FF00 → busy[7]=1 until retire; wd3=0xFFFFFF80. Repeat with LBU → wd3=0x00000080. Repeat LH addr_lo=2 → wd3=0xFFFF80FF.
- Issue 4 loads (rd 1..4) → lq_count=4 and ld_issue_ready=0. Issue a load plus a response in the same cycle on the full queue → issue blocked. Drain 4 responses → writes to a3=1,2,3,4 in order with busy clearing one per retire.
- ALU valid together with mem_rvalid → alu_ready=0 that cycle and load data written. ALU write appears the following cycle.
- Issue load rd=9, then second issue rd=9 → ready=0 until retire. ALU write to rd=9 while busy → written, err_sticky=1.
- Load to x0 and ALU write to x0 → we3 stays 0, lq_count pops. mem_rvalid with empty queue → err_sticky=1. Reset mid-queue → lq_count=0, busy=0.
